ram74189_scan: RTL and testbench

//  Parametrised synchronous successor to the 74189 16x4 RAM: active-low chip select
//  and write enable, inverted read outputs, generic width and depth.

---
 rtl/ram74189_scan.sv | 146 ++++++++++++++
 tb/tb_ram74189_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram74189_scan.sv
// ram74189_scan: synchronous DW x 2**AW RAM in the style of the 74189.
// It has an active-low chip select and an active-low write enable, and its read
// data comes out inverted. It also has a hardware zero-fill sweep and an auto-scan
// port that walks the array at a divided rate to feed the 7-segment converters.
//
// Optional build macro RAM74189_PARITY_EN adds one even-parity bit per word,
// the inj_par input and the par_err output.
//
// state | meaning
// IDLE  | CPU access and auto-scan active
// CLEAR | zero-fill sweep, one word per cycle at ptr; CPU and scan frozen

module ram74189_scan #(
  parameter int DW       = 4,
  parameter int AW       = 4,
  parameter int SCAN_DIV = 25_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_n,
  input  logic          we_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  input  logic          clear,
  input  logic          scan_en,
`ifdef RAM74189_PARITY_EN
  input  logic          inj_par,
  output logic          par_err,
`endif
  output logic [DW-1:0] data_out_n,
  output logic          rd_valid,
  output logic          busy,
  output logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data,
  output logic          scan_tick
);

  localparam int DEPTH = 2**AW;
  localparam int DIV_W = $clog2(SCAN_DIV);
`ifdef RAM74189_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]       state;
  logic [AW-1:0]    ptr;
  logic [DIV_W-1:0] divider;
  logic [MW-1:0]    mem [DEPTH];
  logic [MW-1:0]    wr_word;

  logic in_idle;
  logic start_clear;
  logic do_wr;
  logic do_rd;
  logic scan_run;

  // A clear pulse owns its cycle: no CPU access and no scan step alongside it.
  assign in_idle     = (state == IDLE);
  assign start_clear = in_idle && clear;
  assign do_wr       = in_idle && !clear && !cs_n && !we_n;
  assign do_rd       = in_idle && !clear && !cs_n && we_n;
  assign scan_run    = in_idle && !clear && scan_en;
  assign busy        = (state == CLEAR);

`ifdef RAM74189_PARITY_EN
  assign wr_word = {(^data_in) ^ inj_par, data_in};
`else
  assign wr_word = data_in;
`endif

  // Sequencer for the clear sweep. Reset aborts the sweep and leaves the words already cleared at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_clear) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == AW'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage array. It is deliberately not reset, so the sweep writes '0, which also carries good parity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[ptr] <= '0;
      else if (do_wr)     mem[addr] <= wr_word;
    end
  end

  // CPU read port. A read returns the inverted word one cycle later, and data_out_n holds its value otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_n <= '1;
      rd_valid   <= 1'b0;
`ifdef RAM74189_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      rd_valid <= do_rd;
      if (do_rd) data_out_n <= ~mem[addr][DW-1:0];
`ifdef RAM74189_PARITY_EN
      par_err  <= do_rd & (^mem[addr]);
`endif
    end
  end

  // Auto-scan: the divider advances scan_addr every SCAN_DIV cycles, and scan_data follows the array on every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      divider   <= '0;
      scan_addr <= '0;
      scan_data <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_data <= mem[scan_addr][DW-1:0];
      scan_tick <= 1'b0;
      if (scan_run) begin
        if (divider == DIV_W'(SCAN_DIV - 1)) begin
          divider   <= '0;
          scan_addr <= scan_addr + 1'b1;
          scan_tick <= 1'b1;
        end else begin
          divider <= divider + 1'b1;
        end
      end else if (in_idle && !scan_en) begin
        divider <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram74189_scan.sv
// Directed bench for ram74189_scan. Read expectations go through a scoreboard queue.
module tb_ram74189_scan;

  logic       clk;
  logic       reset;
  logic       cs_n;
  logic       we_n;
  logic [3:0] addr;
  logic [3:0] data_in;
  logic       clear;
  logic       scan_en;
  logic [3:0] data_out_n;
  logic       rd_valid;
  logic       busy;
  logic [3:0] scan_addr;
  logic [3:0] scan_data;
  logic       scan_tick;
`ifdef RAM74189_PARITY_EN
  logic       inj_par;
  logic       par_err;
`endif

  ram74189_scan #(.DW(4), .AW(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs_n       (cs_n),
    .we_n       (we_n),
    .addr       (addr),
    .data_in    (data_in),
    .clear      (clear),
    .scan_en    (scan_en),
`ifdef RAM74189_PARITY_EN
    .inj_par    (inj_par),
    .par_err    (par_err),
`endif
    .data_out_n (data_out_n),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data),
    .scan_tick  (scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [3:0] model [16];
  logic [3:0] exp_q [$];
  int         sdiv;
  logic [3:0] saddr;
  logic [3:0] exp_sd;
  logic       exp_tick;
  int         cnt;
  int         ticks;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    cs_n = 1'b0; we_n = 1'b0; addr = a; data_in = d;
    model[a] = d;
    step();
    cs_n = 1'b1; we_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input string tag);
    cs_n = 1'b0; we_n = 1'b1; addr = a;
    exp_q.push_back(~model[a]);
    step();
    cs_n = 1'b1;
    chk({tag, "_rv"}, rd_valid, 1);
    if (exp_q.size() > 0) chk(tag, data_out_n, exp_q.pop_front());
  endtask

  // Scan reference: advance the model divider by one enabled cycle.
  task automatic scan_model_step();
    if (sdiv == 3) begin
      sdiv = 0; saddr = saddr + 4'd1; exp_tick = 1'b1;
    end else begin
      sdiv++; exp_tick = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; we_n = 1'b1; addr = '0; data_in = '0;
    clear = 1'b0; scan_en = 1'b0;
`ifdef RAM74189_PARITY_EN
    inj_par = 1'b0;
`endif
    step(); step();
    chk("rst_dout", data_out_n, 4'hF);
    chk("rst_rv", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_saddr", scan_addr, 0);
    chk("rst_sdata", scan_data, 0);
    chk("rst_stick", scan_tick, 0);
`ifdef RAM74189_PARITY_EN
    chk("rst_perr", par_err, 0);
`endif
    reset = 1'b0;

    // 1: clear sweep, then read every word back
    clear = 1'b1; step(); clear = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin cnt++; step(); end
    chk("clear_busy_cycles", cnt, 16);
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    for (int i = 0; i < 16; i++) rd(4'(i), "clr_rd");

    // 2: writes, then read
    for (int i = 0; i < 4; i++) wr(4'(i), 4'(i));
    chk("wr_rv0", rd_valid, 0);
    chk("wr_hold", data_out_n, 4'hF);
    rd(4'd2, "rd2");
    chk("rd2_val", data_out_n, 4'b1101);

    // 3: deselected write is ignored
    cs_n = 1'b1; we_n = 1'b0; addr = 4'd1; data_in = 4'hF;
    step();
    we_n = 1'b1;
    chk("nocs_rv", rd_valid, 0);
    rd(4'd1, "nocs_rd");
    chk("nocs_val", data_out_n, 4'b1110);

    // 4: auto-scan with a CPU write to the displayed word
    for (int i = 0; i < 16; i++) wr(4'(i), 4'(i * 7 + 3));
    sdiv = 0; saddr = 4'd0; ticks = 0;
    scan_en = 1'b1;
    for (int c = 0; c < 68; c++) begin
      exp_sd = model[saddr];
      if (c == 10) begin
        cs_n = 1'b0; we_n = 1'b0; addr = saddr; data_in = ~model[saddr];
        model[saddr] = ~model[saddr];
      end
      step();
      cs_n = 1'b1; we_n = 1'b1;
      scan_model_step();
      if (scan_tick === 1'b1) ticks++;
      chk("scan_tick", scan_tick, exp_tick);
      chk("scan_addr", scan_addr, saddr);
      chk("scan_data", scan_data, exp_sd);
    end
    chk("scan_tick_count", ticks, 17);

    // 5a: clear while scanning; CPU access ignored; scan frozen
    clear = 1'b1; step(); clear = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("clr2_busy", busy, 1);
      chk("clr2_stick", scan_tick, 0);
      chk("clr2_saddr", scan_addr, saddr);
      if (k == 6) begin cs_n = 1'b0; we_n = 1'b0; addr = 4'd0; data_in = 4'hA; end
      if (k == 8) begin cs_n = 1'b0; we_n = 1'b1; addr = 4'd3; end
      step();
      if (k == 8) chk("clr2_rd_ign", rd_valid, 0);
      cs_n = 1'b1; we_n = 1'b1;
    end
    chk("clr2_busy_end", busy, 0);
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    for (int c = 0; c < 12; c++) begin
      exp_sd = model[saddr];
      step();
      scan_model_step();
      chk("scan2_tick", scan_tick, exp_tick);
      chk("scan2_addr", scan_addr, saddr);
      chk("scan2_data", scan_data, exp_sd);
    end
    scan_en = 1'b0;
    rd(4'd0, "clr2_wr_ign");

    // 5b: reset in the middle of a sweep
    for (int i = 0; i < 16; i++) wr(4'(i), 4'(i + 1));
    clear = 1'b1; step(); clear = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_saddr", scan_addr, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 4'h0;
    for (int i = 0; i < 8; i++) rd(4'(i), "abort_rd");

`ifdef RAM74189_PARITY_EN
    // 6: parity error injection
    cs_n = 1'b0; we_n = 1'b0; addr = 4'd7; data_in = 4'h5; inj_par = 1'b1;
    model[7] = 4'h5;
    step();
    cs_n = 1'b1; we_n = 1'b1; inj_par = 1'b0;
    rd(4'd7, "par_bad_rd");
    chk("par_bad", par_err, 1);
    rd(4'd3, "par_good_rd");
    chk("par_good", par_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
